// File: rtl/dds_rx_pkg.sv
// Shared types and default widths for the DDS receive-side blocks.
package dds_rx_pkg;

  localparam int DEF_MAG_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_POS,
    S_NEG
  } rx_state_t;

  typedef enum logic [1:0] {
    ZERO,
    POS,
    NEG
  } sample_class_t;

endpackage

// File: rtl/sm_sample_classifier.sv
// Combinational sign-magnitude sample classifier; magnitudes below HYST read as ZERO,
// which also folds negative zero into ZERO.
module sm_sample_classifier
  import dds_rx_pkg::*;
#(
  parameter int MAG_W = DEF_MAG_W,
  parameter int HYST  = 4
) (
  input  logic [MAG_W:0]   sign_mag,
  output sample_class_t    sample_class,
  output logic [MAG_W-1:0] mag
);

  localparam logic [MAG_W-1:0] HYST_MAG = MAG_W'(HYST);

  assign mag = sign_mag[MAG_W-1:0];

  always_comb begin
    sample_class = ZERO;
    if (mag >= HYST_MAG) begin
      sample_class = sign_mag[MAG_W] ? NEG : POS;
    end
  end

endmodule

// File: rtl/dds_tone_detector.sv
// Tone detector: rising-edge period and peak measurement with hysteresis, lock tracking
// and a saturation timeout. All counting is in accepted samples, not clocks.
module dds_tone_detector
  import dds_rx_pkg::*;
#(
  parameter int MAG_W    = DEF_MAG_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HYST     = 4,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [MAG_W:0]   sign_mag_in,
  output logic [CNT_W-1:0] period,
  output logic [MAG_W-1:0] peak_mag,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  LOCK_M = MC_W'(LOCK_CNT);
  localparam logic [CNT_W:0]   TOL_M  = (CNT_W + 1)'(TOL);

  sample_class_t    sample_class;
  logic [MAG_W-1:0] mag;

  sm_sample_classifier #(
    .MAG_W(MAG_W),
    .HYST (HYST)
  ) u_classifier (
    .sign_mag    (sign_mag_in),
    .sample_class(sample_class),
    .mag         (mag)
  );

  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;
  logic [MAG_W-1:0] run_max_reg, run_max_next;
  logic [CNT_W-1:0] prev_period_reg, prev_period_next;
  logic             have_prev_reg, have_prev_next;
  logic [MC_W-1:0]  match_cnt_reg, match_cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [MAG_W-1:0] peak_reg, peak_next;
  logic             period_valid_reg, period_valid_next;
  logic             locked_reg, locked_next;
  logic             timeout_reg, timeout_next;

  // Period difference at one extra bit so the subtraction cannot overflow.
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]        abs_diff;
  logic                  period_match;

  assign diff         = $signed({1'b0, sample_cnt_reg}) - $signed({1'b0, prev_period_reg});
  assign abs_diff     = diff[CNT_W] ? (~diff + 1'b1) : diff;
  assign period_match = have_prev_reg && (abs_diff <= TOL_M);

  always_comb begin
    state_next        = state_reg;
    sample_cnt_next   = sample_cnt_reg;
    run_max_next      = run_max_reg;
    prev_period_next  = prev_period_reg;
    have_prev_next    = have_prev_reg;
    match_cnt_next    = match_cnt_reg;
    period_next       = period_reg;
    peak_next         = peak_reg;
    period_valid_next = 1'b0;
    locked_next       = locked_reg;
    timeout_next      = 1'b0;

    if (sample_valid) begin
      case (state_reg)
        S_IDLE: begin
          if (sample_class == NEG) state_next = S_ARM;
        end
        S_ARM: begin
          if (sample_class == POS) begin
            sample_cnt_next = CNT_W'(1);
            run_max_next    = mag;
            state_next      = S_POS;
          end
        end
        S_POS, S_NEG: begin
          if (state_reg == S_NEG && sample_class == POS) begin
            period_next       = sample_cnt_reg;
            peak_next         = run_max_reg;
            period_valid_next = 1'b1;
            prev_period_next  = sample_cnt_reg;
            have_prev_next    = 1'b1;
            if (period_match) begin
              if (match_cnt_reg != LOCK_M) match_cnt_next = match_cnt_reg + 1'b1;
              locked_next = (match_cnt_next == LOCK_M);
            end else begin
              match_cnt_next = '0;
              locked_next    = 1'b0;
            end
            sample_cnt_next = CNT_W'(1);
            run_max_next    = mag;
            state_next      = S_POS;
          end else if (sample_cnt_reg == {CNT_W{1'b1}}) begin
            // Counter would wrap: give up on this tone and re-arm from scratch.
            timeout_next   = 1'b1;
            locked_next    = 1'b0;
            match_cnt_next = '0;
            have_prev_next = 1'b0;
            state_next     = S_IDLE;
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
            if (mag > run_max_reg) run_max_next = mag;
            if (state_reg == S_POS && sample_class == NEG) state_next = S_NEG;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= S_IDLE;
      sample_cnt_reg   <= '0;
      run_max_reg      <= '0;
      prev_period_reg  <= '0;
      have_prev_reg    <= 1'b0;
      match_cnt_reg    <= '0;
      period_reg       <= '0;
      peak_reg         <= '0;
      period_valid_reg <= 1'b0;
      locked_reg       <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sample_cnt_reg   <= sample_cnt_next;
      run_max_reg      <= run_max_next;
      prev_period_reg  <= prev_period_next;
      have_prev_reg    <= have_prev_next;
      match_cnt_reg    <= match_cnt_next;
      period_reg       <= period_next;
      peak_reg         <= peak_next;
      period_valid_reg <= period_valid_next;
      locked_reg       <= locked_next;
      timeout_reg      <= timeout_next;
    end
  end

  assign period       = period_reg;
  assign peak_mag     = peak_reg;
  assign period_valid = period_valid_reg;
  assign locked       = locked_reg;
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_dds_tone_detector.sv
// Directed bench for dds_tone_detector: sine tones, jitter, tone switch, timeout, gaps, reset.
module tb_dds_tone_detector;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [8:0]  sign_mag_in;
  logic [15:0] period;
  logic [7:0]  peak_mag;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int checks;
  int failures;
  int n_rep;
  int n_to;
  int rep_period [0:63];
  int rep_peak   [0:63];
  int rep_lock   [0:63];

  dds_tone_detector dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sign_mag_in (sign_mag_in),
    .period      (period),
    .peak_mag    (peak_mag),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Report capture away from the active edge.
  always @(negedge clk) begin
    if (period_valid && n_rep < 64) begin
      rep_period[n_rep] = int'(period);
      rep_peak[n_rep]   = int'(peak_mag);
      rep_lock[n_rep]   = int'(locked);
      $display("report %0d: period=%0d peak_mag=%0d locked=%0d", n_rep, period, peak_mag, locked);
      n_rep++;
    end
    if (timeout) begin
      $display("timeout pulse at %0t", $time);
      n_to++;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic [8:0] sine_s(input int i, input int p);
    real v;
    int  m;
    v = 200.0 * $sin(2.0 * 3.14159265358979 * i / p);
    if (v < 0.0) begin
      m = $rtoi(-v + 0.5);
      return {1'b1, 8'(m)};
    end
    m = $rtoi(v + 0.5);
    return {1'b0, 8'(m)};
  endfunction

  task automatic push(input logic [8:0] s, input int gap);
    sign_mag_in  = s;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_tone(input int p, input int nper, input int gap);
    for (int i = 0; i < p * nper; i++) push(sine_s(i % p, p), gap);
  endtask

  initial begin
    checks = 0; failures = 0; n_rep = 0; n_to = 0;
    reset = 1'b0; sample_valid = 1'b0; sign_mag_in = '0;

    // Held in reset with random traffic: everything stays cleared.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      sample_valid = 1'($urandom_range(0, 1));
      sign_mag_in  = 9'($urandom);
    end
    chk("rst_period", int'(period), 0);
    chk("rst_peak", int'(peak_mag), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_timeout", int'(timeout), 0);
    sample_valid = 1'b0;
    reset = 1'b1;
    idle(2);

    // Sub-hysteresis +2/-2 never arms.
    for (int i = 0; i < 1000; i++) push((i % 2) ? 9'h102 : 9'h002, 0);
    idle(2);
    chk("hyst_no_report", n_rep, 0);

    // 256-sample tone: edges from period 1 on, reports from period 2.
    send_tone(256, 6, 0);
    idle(2);
    chk("t256_nrep", n_rep, 4);
    chk("t256_r0_period", rep_period[0], 256);
    chk("t256_r0_peak", rep_peak[0], 200);
    chk("t256_r0_lock", rep_lock[0], 0);
    chk("t256_r2_lock", rep_lock[2], 0);
    chk("t256_r3_lock", rep_lock[3], 1);

    // One extra zero sample stretches a period to 257; still within tolerance.
    push(9'h000, 0);
    send_tone(256, 2, 0);
    idle(2);
    chk("jit_r4_period", rep_period[4], 257);
    chk("jit_r4_lock", rep_lock[4], 1);
    chk("jit_r5_period", rep_period[5], 256);
    chk("jit_r5_lock", rep_lock[5], 1);

    // Phase-continuous switch to a 128-sample tone.
    send_tone(128, 5, 0);
    idle(2);
    chk("sw_nrep", n_rep, 11);
    chk("sw_r6_period", rep_period[6], 256);
    chk("sw_r6_lock", rep_lock[6], 1);
    chk("sw_r7_period", rep_period[7], 128);
    chk("sw_r7_peak", rep_peak[7], 200);
    chk("sw_r7_lock", rep_lock[7], 0);
    chk("sw_r9_lock", rep_lock[9], 0);
    chk("sw_r10_period", rep_period[10], 128);
    chk("sw_r10_lock", rep_lock[10], 1);

    // Constant +100: one edge (period 127, still locked), then saturate.
    push(9'd100, 0);
    for (int i = 0; i < 65534; i++) push(9'd100, 0);
    idle(2);
    chk("to_r11_period", rep_period[11], 127);
    chk("to_r11_lock", rep_lock[11], 1);
    chk("to_before", n_to, 0);
    chk("to_locked_before", int'(locked), 1);
    push(9'd100, 0);
    idle(2);
    chk("to_count", n_to, 1);
    chk("to_locked", int'(locked), 0);
    chk("to_period_hold", int'(period), 127);
    chk("to_peak_hold", int'(peak_mag), 200);
    chk("to_nrep", n_rep, 12);

    // Gapped 256 tone from idle: first report after two edges, gaps ignored.
    send_tone(256, 2, 10);
    push(sine_s(0, 256), 10);
    push(sine_s(1, 256), 10);
    idle(2);
    chk("gap_nrep", n_rep, 13);
    chk("gap_r12_period", rep_period[12], 256);
    chk("gap_r12_peak", rep_peak[12], 200);
    chk("gap_r12_lock", rep_lock[12], 0);

    // Mid-period asynchronous reset clears outputs without a clock edge.
    for (int i = 2; i < 40; i++) push(sine_s(i, 256), 10);
    #2;
    reset = 1'b0;
    #1;
    chk("amid_period", int'(period), 0);
    chk("amid_peak", int'(peak_mag), 0);
    chk("amid_locked", int'(locked), 0);
    chk("amid_pv", int'(period_valid), 0);
    idle(2);
    reset = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
